// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router packet layout, mesh sizing and field helpers
package router_pkg;

  localparam int ROWS    = 4;
  localparam int COLUMS  = 4;
  localparam int N_TERMS = 2 * ROWS + 2 * COLUMS;

  localparam int PCK_SZ = 40;

  // Packet layout: [39:32] destination terminal, [31] mode, [30:0] payload
  localparam int DST_MSB     = 39;
  localparam int DST_LSB     = 32;
  localparam int DST_W       = DST_MSB - DST_LSB + 1;
  localparam int MODE_BIT    = 31;
  localparam int PAYLOAD_MSB = 30;
  localparam int PAYLOAD_LSB = 0;

  function automatic logic [DST_W-1:0] dst_of(input logic [PCK_SZ-1:0] pkt);
    return pkt[DST_MSB:DST_LSB];
  endfunction

endpackage

// File: rtl/router_term_in_fifo_if.sv
// rtl/router_term_in_fifo_if.sv - agent/router facing signal bundle of the terminal ingress fifo
interface router_term_in_fifo_if #(
  parameter int PCK_SZ = 40,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // agent side
  logic              push;
  logic [PCK_SZ-1:0] data_in;
  logic              full;
  logic [CNT_W-1:0]  count;

  // router side
  logic [PCK_SZ-1:0] data_out_i_in;
  logic              pndng_i_in;
  logic              popin;

  // statistics
  logic [15:0]       drop_cnt;
  logic [15:0]       bad_dst_cnt;
  logic              underflow;

  // master drives pushes and pops (agent plus router), slave is the fifo
  modport master (
    output push, data_in, popin,
    input  full, count, data_out_i_in, pndng_i_in, drop_cnt, bad_dst_cnt, underflow
  );

  modport slave (
    input  push, data_in, popin,
    output full, count, data_out_i_in, pndng_i_in, drop_cnt, bad_dst_cnt, underflow
  );

endinterface

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - DEPTH x PCK_SZ register array, one write port, one async read port
module router_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int PCK_SZ = 40,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [PCK_SZ-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [PCK_SZ-1:0] rdata
);

  logic [PCK_SZ-1:0] mem [DEPTH];

  // storage is never reset; the control logic masks stale entries
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_term_in_fifo.sv
// rtl/router_term_in_fifo.sv - show-ahead ingress fifo for one router terminal with drop/reject stats
module router_term_in_fifo #(
  parameter int ROWS    = 4,
  parameter int COLUMS  = 4,
  parameter int PCK_SZ  = router_pkg::PCK_SZ,
  parameter int DEPTH   = 16,
  parameter int TERM_ID = 0
) (
  input  logic                clk,
  input  logic                reset,
  router_term_in_fifo_if.slave bus
);
  import router_pkg::*;

  localparam int N_PORTS = 2 * ROWS + 2 * COLUMS;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [15:0]       drop_q;
  logic [15:0]       bad_q;
  logic              uf_q;
  logic [PCK_SZ-1:0] head;

  logic [DST_W-1:0]  dst;
  logic              legal;
  logic              pndng;
  logic              do_pop;
  logic              do_push;
  logic              do_drop;
  logic              do_bad;
  logic              do_uf;

  assign dst   = dst_of(bus.data_in);
  assign pndng = (count_q != '0);

  // classify this cycle's push/pop; the destination check outranks the full check
  always_comb begin
    legal   = (32'(dst) < N_PORTS) && (32'(dst) != TERM_ID);
    do_pop  = bus.popin && pndng;
    do_uf   = bus.popin && !pndng;
    do_bad  = bus.push && !legal;
    do_push = 1'b0;
    do_drop = 1'b0;
    if (bus.push && legal) begin
      // a pop in the same cycle frees the head slot, so a full fifo still accepts
      if ((count_q < DEPTH_C) || do_pop) begin
        do_push = !reset;
      end else begin
        do_drop = 1'b1;
      end
    end
  end

  router_fifo_mem #(
    .DEPTH  (DEPTH),
    .PCK_SZ (PCK_SZ)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // pointers wrap by explicit compare so any DEPTH >= 2 works; count moves by at most one
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // saturating drop/reject counters and the sticky underflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      bad_q  <= '0;
      uf_q   <= 1'b0;
    end else begin
      if (do_drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (do_bad && (bad_q != 16'hFFFF)) begin
        bad_q <= bad_q + 16'd1;
      end
      if (do_uf) begin
        uf_q <= 1'b1;
      end
    end
  end

  // every output is a function of registered state only
  assign bus.count         = count_q;
  assign bus.full          = (count_q == DEPTH_C);
  assign bus.pndng_i_in    = pndng;
  assign bus.data_out_i_in = pndng ? head : '0;
  assign bus.drop_cnt      = drop_q;
  assign bus.bad_dst_cnt   = bad_q;
  assign bus.underflow     = uf_q;

endmodule

// File: doc/router_term_in_fifo.md
Name: router_term_in_fifo

Overview:
Terminal-side ingress FIFO that feeds one router terminal input.
- Upstream agent pushes 40-bit packets; the block buffers them in order.
- It presents the head packet to the router on data_out_i_in with pndng_i_in and retires it on the router's popin.
- One instance per terminal; 2*ROWS+2*COLUMS instances in total.
- It also drops packets with an illegal destination and keeps drop, reject and underflow statistics.

Parameters:
- ROWS, 4, mesh rows.
- COLUMS, 4, mesh columns.
- PCK_SZ, 40, packet width in bits.
- DEPTH, 16, FIFO entries (any value ≥2; not required to be a power of 2).
- TERM_ID, 0, index of this terminal (0 .. 2*ROWS+2*COLUMS-1).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  agent writes data_in this cycle.
- data_in  in  PCK_SZ  packet from the agent.
- full  out  1  count==DEPTH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- data_out_i_in  out  PCK_SZ  head packet toward the router.
- pndng_i_in  out  1  head valid (count>0).
- popin  in  1  router consumes the head this cycle.
- drop_cnt  out  16  pushes lost because the FIFO was full; saturates at 0xFFFF.
- bad_dst_cnt  out  16  pushes rejected for an illegal destination; saturates at 0xFFFF.
- underflow  out  1  sticky flag: popin seen while pndng_i_in=0.

Behaviour:
- Reset (synchronous, active-high): on the clk edge with reset=1, all of the following are cleared, overriding push and popin that cycle:
  - count=0, pointers=0, pndng_i_in=0, full=0;
  - drop_cnt=0, bad_dst_cnt=0, underflow=0;
  - data_out_i_in=0.
  - Storage contents need not be cleared. A reset mid-stream discards all buffered packets.
- Show-ahead FIFO:
  - data_out_i_in equals the head entry whenever pndng_i_in=1, and 0 when empty.
  - Outputs are registered/derived from state only; there is no combinational path from popin or push to any output.
- Latency: a push accepted at edge N gives pndng_i_in=1 after edge N, i.e. visible in cycle N+1.
- Destination check, using the package DST_MSB:DST_LSB field:
  - A push is legal iff dst < 2*ROWS+2*COLUMS and dst != TERM_ID.
  - An illegal push is never stored; bad_dst_cnt increments by 1.
  - The illegal check takes priority over the full check: an illegal push when full increments only bad_dst_cnt.
- Accept rule: a legal push is stored iff count<DEPTH, or popin && pndng_i_in in the same cycle (full with simultaneous pop → accepted, count stays DEPTH).
- A legal push that is not stored increments drop_cnt.
- Pop rule: popin && pndng_i_in advances the read pointer.
  - popin with pndng_i_in=0 is ignored and sets underflow, which stays set until reset.
- Simultaneous push and pop:
  - Non-empty: count unchanged; order is preserved (the new entry goes to the tail).
  - Empty: the pop is ignored (an underflow, so underflow is set); the push is stored.
- Pointers wrap DEPTH-1 → 0 by explicit compare, so a non-power-of-2 DEPTH works.
- count updates by +1, -1 or 0 per cycle.
- Progress: the block never withholds pndng_i_in while count>0. The router-side liveness check (pndng followed by a pop within 128 cycles) depends on this.

Decomposition:
- Shared package router_pkg holds:
  - PCK_SZ;
  - field constants DST_MSB/DST_LSB, MODE_BIT, PAYLOAD_MSB/LSB;
  - N_TERMS = 2*ROWS+2*COLUMS;
  - function dst_of().
- The same package is used by the router checker.
- One sub-module, router_fifo_mem: a DEPTH×PCK_SZ register array with one write port and one asynchronous read port. The control logic stays in router_term_in_fifo.

Test Plan:
- Reset, then push legal dst=5 (TERM_ID=0) at cycle 1 → pndng_i_in=1 at cycle 2 with the matching data_out_i_in; popin at cycle 3 → count=0 and pndng_i_in=0 at cycle 4.
- Push 16 legal packets with no pops (DEPTH=16) → full=1, count=16; a 17th push → drop_cnt=1 and the contents are unchanged; popin then yields packets 1..16 in order.
- When full, push and popin in the same cycle → count stays 16, drop_cnt unchanged, and the new packet is the last one out.
- Push with dst=0 (equal to TERM_ID) and with dst=16 (≥N_TERMS) → bad_dst_cnt=2, count=0, pndng_i_in never rises.
- popin while empty → underflow=1 and still 1 after 10 idle cycles; reset → underflow=0.
- Fill with 8 packets, assert reset for 1 cycle with push=1 → count=0, pndng_i_in=0, counters 0; the next push is delivered normally.
